// File: rtl/acia_host_seq.sv
// acia_host_seq: polled bus master for a 6850-style ACIA.
// It runs a master reset, writes the control word, and then polls status forever.
// Received bytes go out on a valid/ready port. Transmit bytes come from two
// requesters that share the ACIA through round-robin arbitration.
module acia_host_seq #(
  parameter logic [7:0] CTRL_WORD = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       acia_cs,
  output logic       acia_we,
  output logic       acia_rs,
  output logic [7:0] acia_din,
  input  logic [7:0] acia_dout,
  input  logic [7:0] tx0_data,
  input  logic       tx0_valid,
  output logic       tx0_ready,
  input  logic [7:0] tx1_data,
  input  logic       tx1_valid,
  output logic       tx1_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] err_cnt,
  output logic       init_done
);

  typedef enum logic [2:0] {
    S_RST, S_INIT0, S_INIT1, S_POLL, S_STAT, S_RXRD, S_RXCAP, S_TXWR
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] stat_q;
  logic [7:0] tx_hold;
  logic       last_grant;   // 1 = requester 1 was granted last
  logic       grant;
  logic       grant_sel;    // requester chosen in this STAT cycle

  // State register; reset forces RST at once, so cs drops without a clock edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_RST;
    else        state_reg <= state_next;
  end

  // Next state, bus decode and the STAT-cycle receive/transmit decision
  always_comb begin
    state_next = state_reg;
    acia_cs    = 1'b0;
    acia_we    = 1'b0;
    acia_rs    = 1'b0;
    acia_din   = 8'h00;
    tx0_ready  = 1'b0;
    tx1_ready  = 1'b0;
    grant      = 1'b0;
    grant_sel  = 1'b0;
    case (state_reg)
      S_RST:   state_next = S_INIT0;
      S_INIT0: begin
        acia_cs    = 1'b1;
        acia_we    = 1'b1;
        acia_din   = 8'h03;
        state_next = S_INIT1;
      end
      S_INIT1: begin
        acia_cs    = 1'b1;
        acia_we    = 1'b1;
        acia_din   = CTRL_WORD;
        state_next = S_POLL;
      end
      S_POLL: begin
        acia_cs    = 1'b1;
        state_next = S_STAT;
      end
      S_STAT: begin
        // acia_dout holds the status read during POLL; receive wins over transmit
        if (acia_dout[0] && !rx_valid) begin
          state_next = S_RXRD;
        end else if (acia_dout[1] && (tx0_valid || tx1_valid)) begin
          grant      = 1'b1;
          grant_sel  = (tx0_valid && tx1_valid) ? ~last_grant : tx1_valid;
          tx0_ready  = ~grant_sel;
          tx1_ready  = grant_sel;
          state_next = S_TXWR;
        end else begin
          state_next = S_POLL;
        end
      end
      S_RXRD: begin
        acia_cs    = 1'b1;
        acia_rs    = 1'b1;
        state_next = S_RXCAP;
      end
      S_RXCAP: state_next = S_POLL;
      S_TXWR: begin
        acia_cs    = 1'b1;
        acia_we    = 1'b1;
        acia_rs    = 1'b1;
        acia_din   = tx_hold;
        state_next = S_POLL;
      end
      default: state_next = S_RST;
    endcase
  end

  // Datapath: status latch, transmit hold, arbitration history, receive port, error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q     <= 8'h00;
      tx_hold    <= 8'h00;
      last_grant <= 1'b1;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      err_cnt    <= 8'h00;
      init_done  <= 1'b0;
    end else begin
      if (state_reg == S_INIT1) init_done <= 1'b1;
      if (state_reg == S_STAT)  stat_q <= acia_dout;
      if (grant) begin
        tx_hold    <= grant_sel ? tx1_data : tx0_data;
        last_grant <= grant_sel;
      end
      if (state_reg == S_RXCAP) begin
        // A new byte takes precedence over a handshake in the same cycle
        rx_data  <= acia_dout;
        rx_valid <= 1'b1;
        if (stat_q[4] && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/acia_host_seq.md
# acia_host_seq

Polled bus-master sequencer for the 6850-style ACIA register interface. It replaces CPU-driven access to the ACIA in CPU-less configurations. After reset it issues a master reset and then writes the configuration control word. It then loops forever: it reads status, drains received bytes into a valid/ready output, and writes transmit bytes taken from two valid/ready requesters, which it arbitrates round-robin.

## Interface
Parameters:
- CTRL_WORD, 8'h00, control register value written after master reset. The default means divide-by-1 and no interrupts, since the ACIA is polled.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assertion, active-low
- acia_cs  out  1  ACIA chip select
- acia_we  out  1  ACIA write enable
- acia_rs  out  1  ACIA register select (0 = control/status, 1 = data)
- acia_din  out  8  write data to the ACIA
- acia_dout  in  8  ACIA read data, registered by the ACIA one cycle after the read access
- tx0_data  in  8  requester 0 byte
- tx0_valid  in  1  requester 0 has a byte; must stay asserted with data stable until ready
- tx0_ready  out  1  requester 0 byte accepted this cycle
- tx1_data, tx1_valid, tx1_ready: same as requester 0, for requester 1
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data is valid
- rx_ready  in  1  downstream accepts rx_data
- err_cnt  out  8  saturating count of bytes received with status bit 4 (error) set
- init_done  out  1  init writes are complete; polling is active

## Operation
- States: RST, INIT0, INIT1, POLL, STAT, RXRD, RXCAP, TXWR.
- Bus outputs are decoded from the registered state only. In every state not listed below, cs=we=rs=0 and din=0.
  - INIT0: cs=1, we=1, rs=0, din=8'h03 (master reset).
  - INIT1: cs=1, we=1, rs=0, din=CTRL_WORD.
  - POLL: cs=1, we=0, rs=0 (status read).
  - RXRD: cs=1, we=0, rs=1 (data read).
  - TXWR: cs=1, we=1, rs=1, din=tx_hold.
- Transitions:
  - RST -> INIT0 -> INIT1 -> POLL -> STAT.
  - STAT latches acia_dout into stat_q and decides:
    - RX: if status[0]=1 and rx_valid=0, go to RXRD.
    - Else TX: if status[1]=1 and any txN_valid, grant one requester. Assert its txN_ready for this STAT cycle only, latch its data into tx_hold, and go to TXWR.
    - Else go to POLL.
  - RXRD -> RXCAP. RXCAP loads rx_data from acia_dout and sets rx_valid=1. If stat_q[4]=1, err_cnt increments, saturating at 8'hFF. RXCAP -> POLL.
  - TXWR -> POLL.
- RX has priority over TX in the same STAT cycle.
- RX backpressure: while rx_valid=1, the data register is never read, so the ACIA keeps its full flag. TX continues to be serviced.
- rx_valid clears on the cycle where rx_valid & rx_ready. If RXCAP and the handshake coincide, the new byte wins and rx_valid stays 1. This cannot occur in practice because RXRD requires rx_valid=0.
- Round-robin arbitration uses a last-grant bit, reset value 1, so requester 0 wins the first contention:
  - If both requesters are valid, grant the one not last granted.
  - If only one is valid, grant it.
  - Update the last-grant bit on every grant.
- init_done is 0 until INIT1 completes, then 1 until the next reset.

## Timing
- Reset: all outputs are 0, state is RST, and err_cnt=0. Assertion takes effect immediately, including mid-access: cs drops without waiting for a clock edge and any partial transfer is abandoned. Any held byte is discarded, and its requester has already seen ready.
- After rst_n deasserts, the first edge enters INIT0. INIT0 and INIT1 occupy one cycle each.
- Idle poll period: 2 cycles (POLL, STAT).
- RX latency:
  - RXRD starts 2 cycles after POLL starts.
  - rx_valid rises on the edge ending RXCAP, 4 cycles after POLL starts.
  - The next POLL starts immediately.
- TX latency:
  - txN_ready is high in STAT.
  - The TXWR write cycle is the next cycle.
  - The following POLL observes txe=0.
- txN_ready is never high in two consecutive cycles, and is never high for both requesters at once.

## Test plan
- Reset with CTRL_WORD=8'h15: all outputs 0 during reset. After release, exactly one write of 8'h03 and then one write of 8'h15 to rs=0, with init_done=1 from the first POLL cycle.
- RX with an ACIA model returning status 8'h01 and data 8'hA5, rx_ready=1: rx_valid=1 with rx_data=8'hA5 four cycles after POLL starts, with exactly one data-register read.
- RX backpressure: rx_ready=0 with byte 8'h5A held, status 8'h03, tx0_valid with 8'h42: no rs=1 reads occur and 8'h42 is written. After rx_ready=1 and the handshake, the next STAT issues RXRD.
- Arbitration: tx0 streams 8'h11 and tx1 streams 8'h22, both continuously valid, txe always 1. Write sequence is 11, 22, 11, 22…. With status 8'h03, every RXRD precedes the TX write.
- Errors: three bytes received with status 8'h11 give err_cnt=3. 300 errored bytes give err_cnt=8'hFF.
- Assert rst_n during TXWR: cs falls asynchronously and err_cnt=0. After release, the INIT0/INIT1 writes repeat.
